// File: rtl/vfr_prc_pkg.sv
// Shared definitions for the VFR packet-reader sequencer: reader register map,
// register data constants and the sequencer state encoding.
package vfr_prc_pkg;

    localparam logic [2:0] PRC_REG_CTRL    = 3'd0;
    localparam logic [2:0] PRC_REG_IRQ     = 3'd2;
    localparam logic [2:0] PRC_REG_ADDR    = 3'd3;
    localparam logic [2:0] PRC_REG_TYPE    = 3'd4;
    localparam logic [2:0] PRC_REG_SAMPLES = 3'd5;
    localparam logic [2:0] PRC_REG_WORDS   = 3'd6;

    localparam logic [31:0] PRC_CTRL_GO_IRQEN = 32'h3;
    localparam logic [31:0] PRC_IRQ_CLR       = 32'h2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LOAD_ADDR,
        ST_LOAD_TYPE,
        ST_LOAD_SAMPLES,
        ST_LOAD_WORDS,
        ST_GO,
        ST_WAIT_IRQ,
        ST_CLEAR,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/vfr_prc_sequencer.sv
// Programs the packet reader with a control packet then a video packet per frame,
// re-issuing the last frame when no new descriptor is waiting at a frame boundary.
module vfr_prc_sequencer
    import vfr_prc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH           = 32,
    parameter int unsigned PACKET_SAMPLES_WIDTH = 22,
    parameter int unsigned PACKET_WORDS_WIDTH   = 18,
    parameter int unsigned CTRL_PACKET_TYPE     = 15,
    parameter int unsigned VIDEO_PACKET_TYPE    = 0,
    parameter bit          REPEAT_ENABLE        = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            stopped,
    input  logic                            desc_valid,
    output logic                            desc_ready,
    input  logic [ADDR_WIDTH-1:0]           desc_ctrl_addr,
    input  logic [PACKET_SAMPLES_WIDTH-1:0] desc_ctrl_samples,
    input  logic [PACKET_WORDS_WIDTH-1:0]   desc_ctrl_words,
    input  logic [ADDR_WIDTH-1:0]           desc_video_addr,
    input  logic [PACKET_SAMPLES_WIDTH-1:0] desc_video_samples,
    input  logic [PACKET_WORDS_WIDTH-1:0]   desc_video_words,
    output logic [2:0]                      prc_address,
    output logic                            prc_write,
    output logic [31:0]                     prc_writedata,
    input  logic                            prc_irq,
    output logic                            frame_done,
    output logic [15:0]                     repeat_count
);

    localparam logic [31:0] CTRL_TYPE_WORD  = 32'(4'(CTRL_PACKET_TYPE));
    localparam logic [31:0] VIDEO_TYPE_WORD = 32'(4'(VIDEO_PACKET_TYPE));

    state_t                          state;
    logic                            have_frame;
    logic                            cur_ctrl;
    logic [ADDR_WIDTH-1:0]           ctrl_addr_r;
    logic [PACKET_SAMPLES_WIDTH-1:0] ctrl_samples_r;
    logic [PACKET_WORDS_WIDTH-1:0]   ctrl_words_r;
    logic [ADDR_WIDTH-1:0]           video_addr_r;
    logic [PACKET_SAMPLES_WIDTH-1:0] video_samples_r;
    logic [PACKET_WORDS_WIDTH-1:0]   video_words_r;

    logic        accept;
    logic        sel_ctrl;
    logic [31:0] pkt_addr;
    logic [31:0] pkt_type;
    logic [31:0] pkt_samples;
    logic [31:0] pkt_words;

    assign stopped    = (state == ST_IDLE);
    assign desc_ready = ~reset & enable & ((state == ST_IDLE) | (state == ST_NEXT));
    assign accept     = desc_valid & desc_ready;

    // Packet field mux; in SELECT the choice is made from the latched descriptor.
    always_comb begin
        sel_ctrl = cur_ctrl;
        if (state == ST_SELECT) begin
            sel_ctrl = (ctrl_words_r != '0);
        end
        pkt_addr    = sel_ctrl ? 32'(ctrl_addr_r)    : 32'(video_addr_r);
        pkt_type    = sel_ctrl ? CTRL_TYPE_WORD      : VIDEO_TYPE_WORD;
        pkt_samples = sel_ctrl ? 32'(ctrl_samples_r) : 32'(video_samples_r);
        pkt_words   = sel_ctrl ? 32'(ctrl_words_r)   : 32'(video_words_r);
    end

    // Sequencer: the write for a state is registered on entry so it is visible in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            have_frame      <= 1'b0;
            cur_ctrl        <= 1'b0;
            ctrl_addr_r     <= '0;
            ctrl_samples_r  <= '0;
            ctrl_words_r    <= '0;
            video_addr_r    <= '0;
            video_samples_r <= '0;
            video_words_r   <= '0;
            prc_address     <= '0;
            prc_write       <= 1'b0;
            prc_writedata   <= '0;
            frame_done      <= 1'b0;
            repeat_count    <= '0;
        end else begin
            prc_address   <= '0;
            prc_write     <= 1'b0;
            prc_writedata <= '0;
            frame_done    <= 1'b0;

            if (accept) begin
                ctrl_addr_r     <= desc_ctrl_addr;
                ctrl_samples_r  <= desc_ctrl_samples;
                ctrl_words_r    <= desc_ctrl_words;
                video_addr_r    <= desc_video_addr;
                video_samples_r <= desc_video_samples;
                video_words_r   <= desc_video_words;
                have_frame      <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    cur_ctrl      <= sel_ctrl;
                    state         <= ST_LOAD_ADDR;
                    prc_write     <= 1'b1;
                    prc_address   <= PRC_REG_ADDR;
                    prc_writedata <= pkt_addr;
                end
                ST_LOAD_ADDR: begin
                    state         <= ST_LOAD_TYPE;
                    prc_write     <= 1'b1;
                    prc_address   <= PRC_REG_TYPE;
                    prc_writedata <= pkt_type;
                end
                ST_LOAD_TYPE: begin
                    state         <= ST_LOAD_SAMPLES;
                    prc_write     <= 1'b1;
                    prc_address   <= PRC_REG_SAMPLES;
                    prc_writedata <= pkt_samples;
                end
                ST_LOAD_SAMPLES: begin
                    state         <= ST_LOAD_WORDS;
                    prc_write     <= 1'b1;
                    prc_address   <= PRC_REG_WORDS;
                    prc_writedata <= pkt_words;
                end
                ST_LOAD_WORDS: begin
                    state         <= ST_GO;
                    prc_write     <= 1'b1;
                    prc_address   <= PRC_REG_CTRL;
                    prc_writedata <= PRC_CTRL_GO_IRQEN;
                end
                ST_GO: begin
                    state <= ST_WAIT_IRQ;
                end
                ST_WAIT_IRQ: begin
                    if (prc_irq) begin
                        state         <= ST_CLEAR;
                        prc_write     <= 1'b1;
                        prc_address   <= PRC_REG_IRQ;
                        prc_writedata <= PRC_IRQ_CLR;
                    end
                end
                ST_CLEAR: begin
                    if (cur_ctrl) begin
                        // Control packet done: go straight to loading the video packet.
                        cur_ctrl      <= 1'b0;
                        state         <= ST_LOAD_ADDR;
                        prc_write     <= 1'b1;
                        prc_address   <= PRC_REG_ADDR;
                        prc_writedata <= 32'(video_addr_r);
                    end else begin
                        state      <= ST_NEXT;
                        frame_done <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (desc_valid) begin
                        state <= ST_SELECT;
                    end else if (REPEAT_ENABLE && have_frame) begin
                        state <= ST_SELECT;
                        if (repeat_count != 16'hFFFF) begin
                            repeat_count <= repeat_count + 16'd1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfr_prc_sequencer.sv
// Self-checking bench for vfr_prc_sequencer: table-driven single frames, hand-written
// corner sequences and a randomized run checked against a frame-level write model.
module tb_vfr_prc_sequencer;

    typedef struct {
        logic [31:0] ca;
        logic [21:0] cs;
        logic [17:0] cw;
        logic [31:0] va;
        logic [21:0] vs;
        logic [17:0] vw;
    } desc_t;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        desc_t desc;
        int    n_w;
        wr_t   w[12];
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        desc_valid;
    logic [31:0] desc_ctrl_addr;
    logic [21:0] desc_ctrl_samples;
    logic [17:0] desc_ctrl_words;
    logic [31:0] desc_video_addr;
    logic [21:0] desc_video_samples;
    logic [17:0] desc_video_words;
    logic        prc_irq;
    logic        irq_auto_q;
    logic        irq_man;
    logic        irq_auto;

    logic        stopped, desc_ready, prc_write, frame_done;
    logic [2:0]  prc_address;
    logic [31:0] prc_writedata;
    logic [15:0] repeat_count;

    logic        nr_stopped, nr_desc_ready, nr_prc_write, nr_frame_done;
    logic [2:0]  nr_prc_address;
    logic [31:0] nr_prc_writedata;
    logic [15:0] nr_repeat_count;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  got_base;
    int  fd_cnt;
    int  fd_base;
    int  n_chk;
    int  n_pass;
    vec_t tbl[3];

    assign prc_irq = irq_auto_q | irq_man;

    always #5 clock = ~clock;

    vfr_prc_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .stopped(stopped),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_ctrl_addr(desc_ctrl_addr), .desc_ctrl_samples(desc_ctrl_samples),
        .desc_ctrl_words(desc_ctrl_words), .desc_video_addr(desc_video_addr),
        .desc_video_samples(desc_video_samples), .desc_video_words(desc_video_words),
        .prc_address(prc_address), .prc_write(prc_write), .prc_writedata(prc_writedata),
        .prc_irq(prc_irq), .frame_done(frame_done), .repeat_count(repeat_count)
    );

    vfr_prc_sequencer #(.REPEAT_ENABLE(1'b0)) dut_nr (
        .clock(clock), .reset(reset), .enable(enable), .stopped(nr_stopped),
        .desc_valid(desc_valid), .desc_ready(nr_desc_ready),
        .desc_ctrl_addr(desc_ctrl_addr), .desc_ctrl_samples(desc_ctrl_samples),
        .desc_ctrl_words(desc_ctrl_words), .desc_video_addr(desc_video_addr),
        .desc_video_samples(desc_video_samples), .desc_video_words(desc_video_words),
        .prc_address(nr_prc_address), .prc_write(nr_prc_write), .prc_writedata(nr_prc_writedata),
        .prc_irq(prc_irq), .frame_done(nr_frame_done), .repeat_count(nr_repeat_count)
    );

    // Write and frame_done monitor for the repeating instance.
    always @(negedge clock) begin
        if (!reset && prc_write) begin
            got_q.push_back('{a: prc_address, d: prc_writedata});
        end
        if (!reset && frame_done) begin
            fd_cnt++;
        end
    end

    // Reader model: completion interrupt a few cycles after each GO write.
    initial begin
        int d;
        irq_auto_q = 1'b0;
        forever begin
            @(negedge clock);
            if (irq_auto && !reset && prc_write && prc_address == 3'd0) begin
                d = $urandom_range(0, 3);
                @(posedge clock);
                repeat (d) @(posedge clock);
                @(negedge clock);
                irq_auto_q = 1'b1;
                @(negedge clock);
                irq_auto_q = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic add_packet(input logic [31:0] a, input logic [31:0] t,
                              input logic [31:0] s, input logic [31:0] w);
        exp_q.push_back('{a: 3'd3, d: a});
        exp_q.push_back('{a: 3'd4, d: t});
        exp_q.push_back('{a: 3'd5, d: s});
        exp_q.push_back('{a: 3'd6, d: w});
        exp_q.push_back('{a: 3'd0, d: 32'h3});
        exp_q.push_back('{a: 3'd2, d: 32'h2});
    endtask

    task automatic add_frame(input desc_t ds);
        if (ds.cw != 18'd0) add_packet(ds.ca, 32'd15, 32'(ds.cs), 32'(ds.cw));
        add_packet(ds.va, 32'd0, 32'(ds.vs), 32'(ds.vw));
    endtask

    task automatic check_writes(input string nm);
        int n;
        n = got_q.size() - got_base;
        chk({nm, " write count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            chk($sformatf("%s wr%0d {addr,data}", nm, i),
                64'({got_q[got_base + i].a, got_q[got_base + i].d}),
                64'({exp_q[i].a, exp_q[i].d}));
        end
    endtask

    task automatic set_desc(input desc_t ds);
        desc_ctrl_addr     = ds.ca;
        desc_ctrl_samples  = ds.cs;
        desc_ctrl_words    = ds.cw;
        desc_video_addr    = ds.va;
        desc_video_samples = ds.vs;
        desc_video_words   = ds.vw;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        desc_valid = 1'b0;
        irq_man    = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        got_base = got_q.size();
        fd_base  = fd_cnt;
        exp_q.delete();
    endtask

    task automatic offer(input desc_t ds);
        bit ok;
        ok = 1'b0;
        set_desc(ds);
        desc_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (desc_ready) begin
                @(posedge clock);
                #1 desc_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        desc_valid = 1'b0;
        chk("descriptor accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_fd();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_done within budget", 64'(ok), 64'd1);
    endtask

    task automatic wait_writes(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #2;
            if (got_q.size() - got_base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("%0d writes within budget", n), 64'(ok), 64'd1);
    endtask

    task automatic pulse_irq();
        @(negedge clock);
        irq_man = 1'b1;
        @(negedge clock);
        irq_man = 1'b0;
    endtask

    function automatic desc_t rand_desc();
        desc_t ds;
        ds.ca = $urandom;
        ds.cs = 22'($urandom);
        ds.cw = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'($urandom);
        ds.va = $urandom;
        ds.vs = 22'($urandom);
        ds.vw = 18'($urandom);
        return ds;
    endfunction

    initial begin
        desc_t d_new;
        desc_t d_cur;
        bit    offer_new;
        int    early;
        int    exp_rep;

        n_chk = 0; n_pass = 0; fd_cnt = 0; got_base = 0; fd_base = 0;
        irq_auto = 1'b1;
        set_desc('{ca: 0, cs: 0, cw: 0, va: 0, vs: 0, vw: 0});

        // Single-frame vectors: descriptor in, exact write sequence out.
        tbl[0].desc = '{ca: 32'h1000, cs: 22'd3, cw: 18'd1,
                        va: 32'h2000, vs: 22'd2073600, vw: 18'd207360};
        tbl[0].n_w  = 12;
        tbl[0].w    = '{'{3'd3, 32'h1000}, '{3'd4, 32'd15}, '{3'd5, 32'd3}, '{3'd6, 32'd1},
                        '{3'd0, 32'h3}, '{3'd2, 32'h2},
                        '{3'd3, 32'h2000}, '{3'd4, 32'd0}, '{3'd5, 32'd2073600},
                        '{3'd6, 32'd207360}, '{3'd0, 32'h3}, '{3'd2, 32'h2}};
        tbl[1].desc = '{ca: 32'h3000, cs: 22'd5, cw: 18'd0,
                        va: 32'h4000, vs: 22'd100, vw: 18'd10};
        tbl[1].n_w  = 6;
        tbl[1].w    = '{'{3'd3, 32'h4000}, '{3'd4, 32'd0}, '{3'd5, 32'd100}, '{3'd6, 32'd10},
                        '{3'd0, 32'h3}, '{3'd2, 32'h2},
                        '{3'd0, 32'h0}, '{3'd0, 32'h0}, '{3'd0, 32'h0},
                        '{3'd0, 32'h0}, '{3'd0, 32'h0}, '{3'd0, 32'h0}};
        tbl[2].desc = '{ca: 32'hA000_0000, cs: 22'd1, cw: 18'h3FFFF,
                        va: 32'hFFFF_FFFC, vs: 22'h3FFFFF, vw: 18'h3FFFF};
        tbl[2].n_w  = 12;
        tbl[2].w    = '{'{3'd3, 32'hA000_0000}, '{3'd4, 32'd15}, '{3'd5, 32'd1},
                        '{3'd6, 32'h3FFFF}, '{3'd0, 32'h3}, '{3'd2, 32'h2},
                        '{3'd3, 32'hFFFF_FFFC}, '{3'd4, 32'd0}, '{3'd5, 32'h3FFFFF},
                        '{3'd6, 32'h3FFFF}, '{3'd0, 32'h3}, '{3'd2, 32'h2}};

        for (int v = 0; v < 3; v++) begin
            do_reset();
            chk($sformatf("v%0d reset stopped", v), 64'(stopped), 64'd1);
            chk($sformatf("v%0d reset prc_write", v), 64'(prc_write), 64'd0);
            chk($sformatf("v%0d reset repeat_count", v), 64'(repeat_count), 64'd0);
            chk($sformatf("v%0d reset desc_ready", v), 64'(desc_ready), 64'd0);
            enable = 1'b1;
            offer(tbl[v].desc);
            enable = 1'b0;
            wait_fd();
            @(negedge clock);
            chk($sformatf("v%0d stopped after frame", v), 64'(stopped), 64'd1);
            for (int i = 0; i < tbl[v].n_w; i++) exp_q.push_back(tbl[v].w[i]);
            check_writes($sformatf("v%0d", v));
            chk($sformatf("v%0d frame_done pulses", v), 64'(fd_cnt - fd_base), 64'd1);
        end

        // Repeat: no new descriptor, repeating instance re-issues, other one stops.
        do_reset();
        enable = 1'b1;
        offer(tbl[0].desc);
        wait_fd();
        @(negedge clock);
        chk("repeat count 1", 64'(repeat_count), 64'd1);
        chk("no-repeat stopped", 64'(nr_stopped), 64'd1);
        chk("repeat stopped", 64'(stopped), 64'd0);
        wait_fd();
        @(negedge clock);
        chk("repeat count 2", 64'(repeat_count), 64'd2);
        enable = 1'b0;
        wait_fd();
        @(negedge clock);
        chk("repeat final count", 64'(repeat_count), 64'd2);
        chk("repeat final stopped", 64'(stopped), 64'd1);
        repeat (3) add_frame(tbl[0].desc);
        check_writes("repeat");

        // New descriptor held valid during the video wait: taken only at the frame boundary.
        do_reset();
        enable = 1'b1;
        offer(tbl[0].desc);
        wait_writes(11);
        set_desc(tbl[2].desc);
        desc_valid = 1'b1;
        early = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (frame_done) break;
            if (desc_ready) early++;
        end
        chk("desc_ready before boundary", 64'(early), 64'd0);
        chk("frame_done at boundary", 64'(frame_done), 64'd1);
        chk("desc_ready at boundary", 64'(desc_ready), 64'd1);
        @(posedge clock);
        #1 desc_valid = 1'b0;
        enable = 1'b0;
        wait_fd();
        @(negedge clock);
        chk("new desc repeat_count", 64'(repeat_count), 64'd0);
        add_frame(tbl[0].desc);
        add_frame(tbl[2].desc);
        check_writes("new desc");

        // enable dropped during the control packet wait; spurious irq once idle.
        irq_auto = 1'b0;
        do_reset();
        enable = 1'b1;
        offer(tbl[0].desc);
        wait_writes(5);
        enable = 1'b0;
        pulse_irq();
        wait_writes(11);
        pulse_irq();
        wait_fd();
        @(negedge clock);
        chk("enable drop stopped", 64'(stopped), 64'd1);
        pulse_irq();
        repeat (5) @(negedge clock);
        add_frame(tbl[0].desc);
        check_writes("enable drop");
        chk("enable drop frame_done", 64'(fd_cnt - fd_base), 64'd1);

        // Reset in WAIT_IRQ aborts immediately.
        do_reset();
        enable = 1'b1;
        offer(tbl[0].desc);
        wait_writes(5);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mid reset stopped", 64'(stopped), 64'd1);
        chk("mid reset prc_write", 64'(prc_write), 64'd0);
        chk("mid reset address/data", 64'({prc_address, prc_writedata}), 64'd0);
        chk("mid reset desc_ready", 64'(desc_ready), 64'd0);
        chk("mid reset frame_done", 64'(frame_done), 64'd0);
        enable = 1'b0;
        #1 reset = 1'b0;
        pulse_irq();
        repeat (5) @(negedge clock);
        chk("mid reset writes", 64'(got_q.size() - got_base), 64'd5);
        chk("mid reset stays idle", 64'(stopped), 64'd1);

        // Randomized frames: each boundary takes a new descriptor if one was offered, else repeats.
        irq_auto = 1'b1;
        do_reset();
        enable = 1'b1;
        exp_rep = 0;
        d_cur = rand_desc();
        offer(d_cur);
        add_frame(d_cur);
        for (int f = 1; f <= 8; f++) begin
            offer_new = 1'b0;
            if (f == 8) begin
                enable = 1'b0;
            end else begin
                offer_new = 1'($urandom_range(0, 1));
                if (offer_new) begin
                    d_new = rand_desc();
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                    #1;
                    set_desc(d_new);
                    desc_valid = 1'b1;
                end
            end
            wait_fd();
            @(posedge clock);
            #1 desc_valid = 1'b0;
            if (f != 8) begin
                if (offer_new) d_cur = d_new;
                else exp_rep++;
                add_frame(d_cur);
            end
        end
        repeat (3) @(negedge clock);
        check_writes("random");
        chk("random repeat_count", 64'(repeat_count), 64'(exp_rep));
        chk("random frame_done count", 64'(fd_cnt - fd_base), 64'd8);
        chk("random stopped", 64'(stopped), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
